// File: rtl/boron_round_key_store.sv
// BORON-80 round-key store: expands one cipher key into 26 round keys, one per cycle, then serves indexed reads.
// Ready 26 cycles after an accepted load; read data is registered, 1 cycle. A load during generation is ignored.
module boron_round_key_store #(
  parameter int Key_Bit_Size     = 80,
  parameter int Number_of_Rounds = 26
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    key_load,
  input  logic [Key_Bit_Size-1:0] Key,
  input  logic [4:0]              rk_idx,
  output logic [63:0]             round_key,
  output logic                    busy,
  output logic                    ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(Number_of_Rounds - 1);

  state_t                  state_q, state_d;
  logic [Key_Bit_Size-1:0] w_q, w_d;
  logic [4:0]              c_q, c_d;
  logic                    store_we;
  logic [63:0]             store [Number_of_Rounds];

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;
      4'h1: y = 4'h4;
      4'h2: y = 4'hB;
      4'h3: y = 4'h1;
      4'h4: y = 4'h7;
      4'h5: y = 4'h9;
      4'h6: y = 4'hC;
      4'h7: y = 4'hA;
      4'h8: y = 4'hD;
      4'h9: y = 4'h2;
      4'hA: y = 4'h0;
      4'hB: y = 4'hF;
      4'hC: y = 4'h8;
      4'hD: y = 4'h5;
      4'hE: y = 4'h3;
      default: y = 4'h6;
    endcase
    return y;
  endfunction

  // Rotate left 13, substitute the low nibble, then fold the round counter into bits 63:59.
  function automatic logic [Key_Bit_Size-1:0] update(input logic [Key_Bit_Size-1:0] w,
                                                     input logic [4:0] r);
    logic [Key_Bit_Size-1:0] t;
    t        = {w[Key_Bit_Size-14:0], w[Key_Bit_Size-1:Key_Bit_Size-13]};
    t[3:0]   = sbox(t[3:0]);
    t[63:59] = t[63:59] ^ r;
    return t;
  endfunction

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    c_d      = c_q;
    store_we = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (key_load) begin
          w_d     = Key;
          c_d     = 5'd0;
          state_d = GEN;
        end
      end
      GEN: begin
        store_we = 1'b1;
        w_d      = update(w_q, c_q + 5'd1);
        c_d      = c_q + 5'd1;
        if (c_q == LAST_IDX) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      w_q       <= '0;
      c_q       <= 5'd0;
      round_key <= 64'h0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      c_q     <= c_d;
      if ({27'd0, rk_idx} < 32'(Number_of_Rounds)) round_key <= store[rk_idx];
      else                                         round_key <= 64'h0;
    end
  end

  // Store is deliberately left uncleared; a reset edge must not commit a write.
  always_ff @(posedge clk) begin
    if (store_we && !reset) store[c_q] <= w_q[63:0];
  end

  assign busy  = (state_q == GEN);
  assign ready = (state_q == DONE);

endmodule

// File: tb/tb_boron_round_key_store.sv
// Bench for boron_round_key_store: constant vectors, reference-model sweeps and multi-cycle corner sequences.
module tb_boron_round_key_store;

  localparam int NR = 26;
  localparam logic [79:0] ONES = {80{1'b1}};
  localparam logic [3:0] SB [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                     4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};

  logic        clk = 1'b0;
  logic        reset;
  logic        key_load;
  logic [79:0] Key;
  logic [4:0]  rk_idx;
  logic [63:0] round_key;
  logic        busy;
  logic        ready;

  int checks   = 0;
  int failures = 0;
  logic [63:0] model [NR];

  boron_round_key_store #(.Key_Bit_Size(80), .Number_of_Rounds(NR)) dut (
    .clk(clk), .reset(reset), .key_load(key_load), .Key(Key),
    .rk_idx(rk_idx), .round_key(round_key), .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] key;
    logic [4:0]  idx;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Round keys straight from the schedule definition.
  task automatic gen_model(input logic [79:0] k);
    logic [79:0] w;
    w = k;
    for (int r = 0; r < NR; r++) begin
      model[r] = w[63:0];
      w = (w << 13) | (w >> 67);
      w[3:0] = SB[w[3:0]];
      w[63:59] = w[63:59] ^ 5'(r + 1);
    end
  endtask

  task automatic load_key(input logic [79:0] k);
    @(negedge clk);
    key_load = 1'b1;
    Key      = k;
    @(posedge clk);
    #1;
    key_load = 1'b0;
  endtask

  task automatic wait_ready(input int max, output int cyc);
    cyc = 0;
    while (cyc < max) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ready) return;
    end
    cyc = -1;
  endtask

  task automatic rd(input int idx, output logic [63:0] v);
    @(negedge clk);
    rk_idx = 5'(idx);
    @(posedge clk);
    #1;
    v = round_key;
  endtask

  task automatic load_and_check(input string name, input logic [79:0] k);
    int cyc;
    load_key(k);
    chk({name, "_busy_after_accept"}, 64'(busy), 64'd1);
    chk({name, "_ready_after_accept"}, 64'(ready), 64'd0);
    wait_ready(40, cyc);
    chk({name, "_latency"}, 64'(cyc), 64'(NR));
  endtask

  task automatic sweep(input string name);
    logic [63:0] v;
    for (int i = 0; i < NR; i++) begin
      rd(i, v);
      chk($sformatf("%s_idx%0d", name, i), v, model[i]);
    end
  endtask

  vec_t vecs [8];

  initial begin
    logic [63:0] v;
    logic [79:0] cur_key;
    logic [79:0] ka, kb;
    bit          have_key;
    int          cyc;

    vecs[0] = '{key: 80'h0, idx: 5'd0,  exp: 64'h0};
    vecs[1] = '{key: 80'h0, idx: 5'd1,  exp: 64'h080000000000000E};
    vecs[2] = '{key: 80'h0, idx: 5'd26, exp: 64'h0};
    vecs[3] = '{key: 80'h0, idx: 5'd31, exp: 64'h0};
    vecs[4] = '{key: ONES,  idx: 5'd0,  exp: 64'hFFFFFFFFFFFFFFFF};
    vecs[5] = '{key: ONES,  idx: 5'd1,  exp: 64'hF7FFFFFFFFFFFFF6};
    vecs[6] = '{key: ONES,  idx: 5'd26, exp: 64'h0};
    vecs[7] = '{key: ONES,  idx: 5'd31, exp: 64'h0};

    reset = 1'b1; key_load = 1'b0; Key = '0; rk_idx = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_round_key", round_key, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Fixed vectors from the schedule's known values.
    have_key = 1'b0;
    cur_key  = '0;
    for (int i = 0; i < 8; i++) begin
      if (!have_key || cur_key != vecs[i].key) begin
        load_and_check($sformatf("vec%0d_load", i), vecs[i].key);
        cur_key  = vecs[i].key;
        have_key = 1'b1;
      end
      rd(int'(vecs[i].idx), v);
      chk($sformatf("vec%0d", i), v, vecs[i].exp);
    end
    gen_model(ONES);
    sweep("ones");

    // Descending read, one index per cycle.
    for (int i = NR - 1; i >= 0; i--) begin
      rd(i, v);
      chk($sformatf("desc_idx%0d", i), v, model[i]);
    end

    // Random keys, random read order including out-of-range indices.
    for (int t = 0; t < 4; t++) begin
      ka = {16'($urandom), $urandom, $urandom};
      gen_model(ka);
      load_and_check($sformatf("rnd%0d", t), ka);
      for (int j = 0; j < 20; j++) begin
        int idx;
        idx = int'($urandom_range(0, 31));
        rd(idx, v);
        chk($sformatf("rnd%0d_idx%0d", t, idx), v, (idx < NR) ? model[idx] : 64'h0);
      end
    end

    // Second load during generation must be ignored.
    ka = 80'h0123456789ABCDEF0123;
    kb = 80'hFEDCBA9876543210FEDC;
    gen_model(ka);
    load_key(ka);
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      key_load = (k == 10);
      Key      = (k == 10) ? kb : ka;
      @(posedge clk);
      #1;
      if (ready) begin
        cyc = k;
        break;
      end
    end
    key_load = 1'b0;
    chk("ignored_reload_latency", 64'(cyc), 64'(NR));
    sweep("ignored_reload");

    // Reset mid-generation, with a simultaneous load that must be dropped.
    load_key(ONES);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; key_load = 1'b1; Key = ONES;
    @(posedge clk);
    #1;
    chk("midgen_reset_busy", 64'(busy), 64'd0);
    chk("midgen_reset_ready", 64'(ready), 64'd0);
    @(negedge clk);
    reset = 1'b0; key_load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("after_reset_busy", 64'(busy), 64'd0);
    chk("after_reset_ready", 64'(ready), 64'd0);
    gen_model(80'h0);
    load_and_check("post_reset_zero", 80'h0);
    sweep("post_reset_zero");

    // Reload in the first DONE cycle.
    load_key(80'h0);
    wait_ready(40, cyc);
    chk("b2b_first_latency", 64'(cyc), 64'(NR));
    @(negedge clk);
    key_load = 1'b1; Key = ONES;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    chk("b2b_ready_drop", 64'(ready), 64'd0);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_ready(40, cyc);
    chk("b2b_second_latency", 64'(cyc), 64'(NR));
    gen_model(ONES);
    sweep("b2b_ones");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
